// File: rtl/round_scheduler.sv
// Round-robin front end sharing one convergent-rounding unit among NREQ requesters.
// Two-stage pipeline: S0 holds the captured sample, its shift and channel; S1 holds the
// rounded result. Per-requester shift settings choose which OWID-bit field is kept.
module round_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IWID = 16,
  parameter int unsigned OWID = 8,
  parameter int unsigned SWID = 4,
  localparam int unsigned CW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_areset_n,
  input  logic                 i_ce,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*IWID-1:0] i_req_val,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic                 i_cfg_we,
  input  logic [CW-1:0]        i_cfg_idx,
  input  logic [SWID-1:0]      i_cfg_shift,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OWID-1:0]      o_val,
  output logic [CW-1:0]        o_chan,
  output logic                 o_sat,
  input  logic                 i_sat_clr,
  output logic [15:0]          o_sat_cnt
);

  localparam logic [SWID-1:0] MaxShift = SWID'(IWID - OWID);
  localparam logic [OWID-1:0] MaxPos   = {1'b0, {(OWID - 1){1'b1}}};

  logic [SWID-1:0] shift_q [NREQ];
  logic [CW-1:0]   last_grant_q, last_grant_d;

  logic            s0_valid_q;
  logic [IWID-1:0] s0_val_q;
  logic [SWID-1:0] s0_shift_q;
  logic [CW-1:0]   s0_chan_q;

  logic            out_valid_q;
  logic [OWID-1:0] out_val_q;
  logic [CW-1:0]   out_chan_q;
  logic            out_sat_q;
  logic [15:0]     sat_cnt_q, sat_cnt_d;

  logic            s1_load, s0_load, xfer, found;
  logic [CW-1:0]   grant_idx;
  logic [NREQ-1:0] grant;
  logic [SWID-1:0] cfg_shift_clamped;

  logic [SWID-1:0] drop;
  logic [IWID-1:0] low_mask;
  logic [OWID-1:0] kept, rounded;
  logic            guard, sticky, round_up, sat;

  assign s1_load = i_ce & (~out_valid_q | i_ready);
  assign s0_load = i_ce & (~s0_valid_q | s1_load);
  assign xfer    = s0_load & found;

  assign cfg_shift_clamped = (i_cfg_shift > MaxShift) ? MaxShift : i_cfg_shift;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic [31:0]   idx;
    logic [CW-1:0] cidx;
    found     = 1'b0;
    grant_idx = last_grant_q;
    idx       = '0;
    cidx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx  = (32'(last_grant_q) + i + 1) % NREQ;
      cidx = CW'(idx);
      if (!found && i_req_valid[cidx]) begin
        found     = 1'b1;
        grant_idx = cidx;
      end
    end
    grant = found ? (NREQ'(1) << grant_idx) : '0;
    // Held low during reset so no handshake is implied while state is being cleared.
    o_req_ready  = (s0_load && i_areset_n) ? grant : '0;
    last_grant_d = xfer ? grant_idx : last_grant_q;
  end

  // Convergent (round-half-to-even) reduction of the S0 sample to OWID bits.
  always_comb begin
    drop     = MaxShift - s0_shift_q;
    low_mask = (IWID'(1) << drop) - IWID'(1);
    kept     = OWID'(s0_val_q >> drop);
    // Top bit of the dropped field is the guard; everything below it is sticky.
    guard    = |(s0_val_q & low_mask & ~(low_mask >> 1));
    sticky   = |(s0_val_q & (low_mask >> 1));
    round_up = guard & (sticky | kept[0]);
    sat      = round_up & (kept == MaxPos);
    rounded  = sat ? MaxPos : kept + OWID'(round_up);
  end

  // Saturating count of saturated results; clear wins over increment.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (i_sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && i_ready && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // Per-requester shift table.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int unsigned k = 0; k < NREQ; k++) shift_q[k] <= '0;
    end else if (i_ce && i_cfg_we) begin
      shift_q[i_cfg_idx] <= cfg_shift_clamped;
    end
  end

  // Arbiter pointer and stage S0 capture.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      last_grant_q <= CW'(NREQ - 1);
      s0_valid_q   <= 1'b0;
      s0_val_q     <= '0;
      s0_shift_q   <= '0;
      s0_chan_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      if (s0_load) begin
        s0_valid_q <= xfer;
        if (xfer) begin
          s0_val_q   <= i_req_val[grant_idx*IWID +: IWID];
          s0_shift_q <= shift_q[grant_idx];
          s0_chan_q  <= grant_idx;
        end
      end
    end
  end

  // Stage S1 output registers; held while stalled by i_ready.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      out_chan_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (s1_load) begin
      out_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        out_val_q  <= rounded;
        out_chan_q <= s0_chan_q;
        out_sat_q  <= sat;
      end
    end
  end

  // Saturation counter register.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      sat_cnt_q <= '0;
    end else if (i_ce) begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_valid   = out_valid_q;
  assign o_val     = out_val_q;
  assign o_chan    = out_chan_q;
  assign o_sat     = out_sat_q;
  assign o_sat_cnt = sat_cnt_q;

endmodule

// File: doc/round_scheduler.md
ROUND_SCHEDULER -- requirements
Module: round_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one rounding unit.
REQ-002 Parameter IWID, default 16, input sample width (signed).
REQ-003 Parameter OWID, default 8, output sample width (signed); IWID > OWID.
REQ-004 Parameter SWID, default 4, shift-config width; must hold IWID-OWID.
REQ-005 One clock; reset is asynchronous and active-low, ports i_clk and i_areset_n.
REQ-006 i_clk  in  1  rising-edge clock.
REQ-007 i_areset_n  in  1  async active-low reset.
REQ-008 i_ce  in  1  clock enable; when low, no state changes except reset.
REQ-009 i_req_valid  in  NREQ  per-requester sample valid.
REQ-010 i_req_val  in  NREQ*IWID  per-requester samples, requester k at bits [k*IWID +: IWID].
REQ-011 o_req_ready  out  NREQ  per-requester accept strobe, combinational.
REQ-012 i_cfg_we  in  1  shift-config write strobe.
REQ-013 i_cfg_idx  in  clog2(NREQ)  requester index for the config write.
REQ-014 i_cfg_shift  in  SWID  new SHIFT for that requester.
REQ-015 o_valid  out  1  result valid.
REQ-016 i_ready  in  1  downstream accept.
REQ-017 o_val  out  OWID  rounded result (signed).
REQ-018 o_chan  out  clog2(NREQ)  source requester of o_val.
REQ-019 o_sat  out  1  o_val was saturated.
REQ-020 i_sat_clr  in  1  clears o_sat_cnt.
REQ-021 o_sat_cnt  out  16  saturating count of saturated results.

Function
REQ-022 A transfer occurs on requester k in a cycle with i_ce=1, i_req_valid[k]=1 and o_req_ready[k]=1; the requester holds valid and data until then.
REQ-023 Pipeline: stage S0 (captured sample, shift, channel) and stage S1 (output registers); S1 loads when i_ce & (!o_valid | i_ready); S0 loads when i_ce & (!s0_valid | S1 loads).
REQ-024 o_req_ready is one-hot or zero; it is nonzero only when S0 loads, for the round-robin winner.
REQ-025 Round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates only on a transfer.
REQ-026 Latency: a transfer in cycle t gives o_valid=1 in cycle t+2 when not back-pressured; sustained throughput is one result per cycle.
REQ-027 With o_valid=1 and i_ready=0, o_val, o_chan and o_sat hold stable.
REQ-028 Shift is sampled into S0 at transfer; a config write in the same cycle as a transfer for that channel takes effect for later transfers only.
REQ-029 Config writes with i_cfg_shift > IWID-OWID store IWID-OWID.
REQ-030 Dropped bits D = IWID-OWID-shift; kept field = i_val[IWID-1-shift : D].
REQ-031 D=0: o_val = kept field, no rounding.
REQ-032 D>=1: round half to even. Round up when the first dropped bit is 1 and either any lower dropped bit is 1 or the kept LSB is 1; otherwise truncate.
REQ-033 When a round-up would wrap past the maximum positive value, o_val = 2^(OWID-1)-1 and o_sat=1; otherwise o_sat=0.
REQ-034 o_sat_cnt increments once per output handshake (o_valid & i_ready & i_ce) with o_sat=1; it saturates at 0xFFFF.
REQ-035 i_sat_clr has priority over an increment in the same cycle; the count becomes 0.

Reset
REQ-036 On reset, clear the following regardless of i_ce:
- o_valid, s0_valid, o_val, o_chan, o_sat and o_sat_cnt = 0.
- All stored shifts = 0.
- last_grant = NREQ-1, so requester 0 has first priority.
REQ-037 Reset asserted mid-operation discards in-flight samples; no output handshake occurs for them after release.

Verification
REQ-038 Convergent rounding, shift 0, ch0, i_ready=1:
- 0x1280 -> 0x12
- 0x1380 -> 0x14
- 0x1281 -> 0x13
- 0xFF80 -> 0x00
Each result appears 2 cycles after the transfer.
REQ-039 Saturation: 0x7F80 with shift 0 -> o_val=0x7F, o_sat=1, o_sat_cnt=1; a following i_sat_clr -> o_sat_cnt=0.
REQ-040 Config:
- Write ch2 shift=8, send 0x12AB -> o_val=0xAB.
- Write ch2 shift=15 -> stored value is 8.
REQ-041 Arbitration: all 4 requesters valid continuously, i_ready=1 -> o_chan sequence 0,1,2,3,0,1 with one result per cycle.
REQ-042 Backpressure: i_ready=0 with all requesters valid:
- Exactly 2 transfers are accepted, then o_req_ready=0.
- o_val stays stable.
- Raising i_ready resumes with no loss or duplication.
REQ-043 Reset mid-stream: assert i_areset_n=0 with S0 and S1 full -> all outputs 0 immediately; after release, the first grant goes to ch0.
